// File: rtl/ft245_dac_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ft245_dac_loader_if                                          |
// | Description : Bundle of the FT245RL byte-engine handshake and the DAC pin  |
// |               bus seen by ft245_dac_loader.                                |
// |   RX_DONE     1  one-cycle pulse, RX_DATA valid                            |
// |   RX_DATA     8  received byte                                             |
// |   TX_VALID    1  high = FT245 TX busy / buffer full                        |
// |   TX_DONE     1  one-cycle pulse, byte handed to FT245                     |
// |   TXEN        1  one-cycle request to send TX_DATA                         |
// |   TX_DATA     8  byte to send                                              |
// |   DAC_CLK     1  DAC latch clock                                           |
// |   DAC_DATA   12  DAC sample                                                |
// |   PLAY_ACTIVE 1  playback running                                          |
// |   LOAD_DONE   1  one-cycle pulse when the final word is written            |
// |   slave  modport : the loader itself                                       |
// |   master modport : byte engine / DAC side driving and observing it         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface ft245_dac_loader_if;
   logic        RX_DONE;
   logic [7:0]  RX_DATA;
   logic        TX_VALID;
   logic        TX_DONE;
   logic        TXEN;
   logic [7:0]  TX_DATA;
   logic        DAC_CLK;
   logic [11:0] DAC_DATA;
   logic        PLAY_ACTIVE;
   logic        LOAD_DONE;

   modport slave (
      input  RX_DONE, RX_DATA, TX_VALID, TX_DONE,
      output TXEN, TX_DATA, DAC_CLK, DAC_DATA, PLAY_ACTIVE, LOAD_DONE
   );

   modport master (
      output RX_DONE, RX_DATA, TX_VALID, TX_DONE,
      input  TXEN, TX_DATA, DAC_CLK, DAC_DATA, PLAY_ACTIVE, LOAD_DONE
   );
endinterface
`default_nettype wire

// File: rtl/ft245_dac_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ft245_dac_loader                                             |
// | Description : Parses host command bytes from the FT245RL RX side, loads    |
// |               little-endian 16-bit samples into a waveform RAM, returns an |
// |               ACK byte on the TX side and replays the RAM to a 12-bit DAC. |
// |   CLK  in  1  system clock                                                 |
// |   RST  in  1  asynchronous, active-low reset                               |
// |   bus  ft245_dac_loader_if.slave : RX/TX handshake and DAC outputs         |
// |   Commands (IDLE, low nibble): 3 LOAD, 4 DIV (high nibble), 5 PLAY, 6 STOP |
// |   Option macro LOAD_CHECKSUM_EN: trailing XOR checksum byte after a load,  |
// |               ACK_BAD on mismatch and no LOAD_DONE.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ft245_dac_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned SAMPLE_NUM = 1000,
   parameter logic [7:0]  ACK_OK     = 8'hA5,
   parameter logic [7:0]  ACK_BAD    = 8'h5A
) (
   input  logic              CLK,
   input  logic              RST,
   ft245_dac_loader_if.slave bus
);
   localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_NUM - 1);
   localparam logic [7:0]            DIV_RESET = 8'd3;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD_L    = 3'd1;
   localparam logic [2:0] S_LOAD_H    = 3'd2;
   localparam logic [2:0] S_LOAD_CSUM = 3'd3;
   localparam logic [2:0] S_ACK_WAIT  = 3'd4;
   localparam logic [2:0] S_ACK_SEND  = 3'd5;

   localparam logic [3:0] CMD_LOAD = 4'd3;
   localparam logic [3:0] CMD_DIV  = 4'd4;
   localparam logic [3:0] CMD_PLAY = 4'd5;
   localparam logic [3:0] CMD_STOP = 4'd6;

   logic [2:0]            state_q,     state_d;
   logic [ADDR_WIDTH-1:0] waddr_q,     waddr_d;
   logic [ADDR_WIDTH-1:0] raddr_q,     raddr_d;
   logic [7:0]            low_q,       low_d;
   logic [7:0]            csum_q,      csum_d;
   logic [7:0]            ack_q,       ack_d;
   logic [7:0]            div_q,       div_d;      // divider as last configured
   logic [7:0]            div_act_q,   div_act_d;  // divider governing the running period
   logic [7:0]            cnt_q,       cnt_d;
   logic                  play_q,      play_d;
   logic                  dac_clk_q,   dac_clk_d;
   logic [11:0]           dac_data_q,  dac_data_d;
   logic                  txen_q,      txen_d;
   logic [7:0]            tx_data_q,   tx_data_d;
   logic                  load_done_q, load_done_d;

   logic                  rx_cmd;
   logic                  cmd_load, cmd_div, cmd_play, cmd_stop;
   logic                  csum_match;
   logic [7:0]            dac_half;
   logic                  ram_we;

   logic [15:0]           mem [DEPTH];
   logic [15:0]           rd_data_q;
   logic                  rd_hi_unused;

   // The RAM is read every cycle at raddr_q. raddr_q only moves at a period
   // wrap and a period is at least two cycles, so rd_data_q is settled on the
   // new word well before the next wrap consumes it.
   always_ff @(posedge CLK) begin
      if (ram_we) begin
         mem[waddr_q] <= {bus.RX_DATA, low_q};
      end
      rd_data_q <= mem[raddr_q];
   end

   // Upper nibble of each word is stored but never drives the DAC.
   assign rd_hi_unused = ^rd_data_q[15:12];

   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      low_d       = low_q;
      csum_d      = csum_q;
      ack_d       = ack_q;
      div_d       = div_q;
      div_act_d   = div_act_q;
      cnt_d       = cnt_q;
      play_d      = play_q;
      dac_data_d  = dac_data_q;
      tx_data_d   = tx_data_q;
      txen_d      = 1'b0;
      load_done_d = 1'b0;
      ram_we      = 1'b0;
      csum_match  = 1'b0;

      rx_cmd   = bus.RX_DONE && (state_q == S_IDLE);
      cmd_load = rx_cmd && (bus.RX_DATA[3:0] == CMD_LOAD);
      cmd_div  = rx_cmd && (bus.RX_DATA[3:0] == CMD_DIV);
      cmd_play = rx_cmd && (bus.RX_DATA[3:0] == CMD_PLAY);
      cmd_stop = rx_cmd && (bus.RX_DATA[3:0] == CMD_STOP);

      // Playback timebase; any playback command on this cycle freezes the
      // output so DAC_DATA holds its last value on STOP/LOAD.
      if (play_q && !cmd_load && !cmd_play && !cmd_stop) begin
         if (cnt_q == div_act_q) begin
            cnt_d      = '0;
            dac_data_d = rd_data_q[11:0];
            raddr_d    = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
            div_act_d  = div_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      if (cmd_play) begin
         play_d    = 1'b1;
         raddr_d   = '0;
         cnt_d     = '0;
         div_act_d = div_q;
      end
      if (cmd_stop || cmd_load) begin
         play_d = 1'b0;
         cnt_d  = '0;
      end
      if (cmd_div) begin
         div_d = (bus.RX_DATA[7:4] == 4'd0) ? 8'd1 : {4'd0, bus.RX_DATA[7:4]};
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_load) begin
               state_d = S_LOAD_L;
               waddr_d = '0;
               csum_d  = '0;
            end
         end
         S_LOAD_L: begin
            if (bus.RX_DONE) begin
               low_d   = bus.RX_DATA;
               csum_d  = csum_q ^ bus.RX_DATA;
               state_d = S_LOAD_H;
            end
         end
         S_LOAD_H: begin
            if (bus.RX_DONE) begin
               ram_we  = 1'b1;
               csum_d  = csum_q ^ bus.RX_DATA;
               waddr_d = waddr_q + 1'b1;
               if (waddr_q == LAST_ADDR) begin
`ifdef LOAD_CHECKSUM_EN
                  state_d = S_LOAD_CSUM;
`else
                  load_done_d = 1'b1;
                  ack_d       = ACK_OK;
                  state_d     = S_ACK_WAIT;
`endif
               end else begin
                  state_d = S_LOAD_L;
               end
            end
         end
         // Only reachable when the checksum option is built in.
         S_LOAD_CSUM: begin
            if (bus.RX_DONE) begin
               csum_match  = (bus.RX_DATA == csum_q);
               load_done_d = csum_match;
               ack_d       = csum_match ? ACK_OK : ACK_BAD;
               state_d     = S_ACK_WAIT;
            end
         end
         S_ACK_WAIT: begin
            if (!bus.TX_VALID) begin
               txen_d    = 1'b1;
               tx_data_d = ack_q;
               state_d   = S_ACK_SEND;
            end
         end
         S_ACK_SEND: begin
            if (bus.TX_DONE) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // DAC_CLK is registered from next-state values so the pin is glitch-free
      // and falls on the same edge that updates DAC_DATA.
      dac_half  = 8'((9'(div_act_d) + 9'd1) >> 1);
      dac_clk_d = play_d && (cnt_d >= dac_half);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         waddr_q     <= '0;
         raddr_q     <= '0;
         low_q       <= '0;
         csum_q      <= '0;
         ack_q       <= ACK_OK;
         div_q       <= DIV_RESET;
         div_act_q   <= DIV_RESET;
         cnt_q       <= '0;
         play_q      <= 1'b0;
         dac_clk_q   <= 1'b0;
         dac_data_q  <= '0;
         txen_q      <= 1'b0;
         tx_data_q   <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         low_q       <= low_d;
         csum_q      <= csum_d;
         ack_q       <= ack_d;
         div_q       <= div_d;
         div_act_q   <= div_act_d;
         cnt_q       <= cnt_d;
         play_q      <= play_d;
         dac_clk_q   <= dac_clk_d;
         dac_data_q  <= dac_data_d;
         txen_q      <= txen_d;
         tx_data_q   <= tx_data_d;
         load_done_q <= load_done_d;
      end
   end

   assign bus.TXEN        = txen_q;
   assign bus.TX_DATA     = tx_data_q;
   assign bus.DAC_CLK     = dac_clk_q;
   assign bus.DAC_DATA    = dac_data_q;
   assign bus.PLAY_ACTIVE = play_q;
   assign bus.LOAD_DONE   = load_done_q;
endmodule
`default_nettype wire

// File: tb/tb_ft245_dac_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ft245_dac_loader                                          |
// | Description : Self-checking bench for ft245_dac_loader: ramp and random    |
// |               loads, ACK hand-off, playback timing against a sample-rate   |
// |               model, DIV/STOP/LOAD interplay and reset mid-play.           |
// |               Honours LOAD_CHECKSUM_EN when defined.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ft245_dac_loader;
   localparam int N = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          ld_cnt = 0;
   int          tx_cnt = 0;
   logic [7:0]  tx_last = 8'h00;
   logic [15:0] ram_model [N];

   ft245_dac_loader_if bus();

   ft245_dac_loader dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; look at outputs 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.LOAD_DONE === 1'b1) ld_cnt++;
      if (bus.TXEN === 1'b1) begin
         tx_cnt++;
         tx_last = bus.TX_DATA;
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.RX_DATA = b;
      bus.RX_DONE = 1'b1;
      tick();
      bus.RX_DONE = 1'b0;
   endtask

   task automatic gap();
      tick_n($urandom_range(0, 2));
   endtask

   // Expected DAC value n cycles after a PLAY is accepted: a new word every
   // d+1 cycles, first word after one full period, wrapping over N words.
   function automatic logic [11:0] dac_model(input int d, input int n, input logic [11:0] prev);
      int k;
      k = n / (d + 1);
      if (k == 0) return prev;
      return ram_model[(k - 1) % N][11:0];
   endfunction

   task automatic do_load(input bit bad_csum, input bit send_cmd, input string tag);
      logic [7:0] x;
      x = 8'h00;
      ld_cnt = 0;
      if (send_cmd) begin
         send_byte(8'h03);
         gap();
      end
      for (int i = 0; i < N; i++) begin
         send_byte(ram_model[i][7:0]);
         gap();
         send_byte(ram_model[i][15:8]);
         x = x ^ ram_model[i][7:0] ^ ram_model[i][15:8];
         if (i < N - 1) gap();
      end
`ifdef LOAD_CHECKSUM_EN
      check({tag, "_load_done_before_csum"}, bus.LOAD_DONE, 0);
      gap();
      send_byte(bad_csum ? (x ^ 8'h5C) : x);
      check({tag, "_load_done_at_csum"}, bus.LOAD_DONE, bad_csum ? 0 : 1);
`else
      check({tag, "_load_done_at_last_word"}, bus.LOAD_DONE, 1);
`endif
      tick_n(2);
      check({tag, "_load_done_pulses"}, ld_cnt, bad_csum ? 0 : 1);
   endtask

   // TX_VALID is already high; hold it for 'hold' cycles while throwing
   // command bytes that must be ignored, then release and expect one ACK.
   task automatic ack_phase(input int hold, input logic [7:0] exp_ack, input string tag);
      tx_cnt = 0;
      for (int i = 0; i < hold; i++) begin
         if (i == 3) send_byte(8'h05);
         else if (i == 6) send_byte(8'h03);
         else tick();
      end
      check({tag, "_txen_held_off"}, tx_cnt, 0);
      check({tag, "_rx_in_ack_discarded"}, bus.PLAY_ACTIVE, 0);
      bus.TX_VALID = 1'b0;
      for (int i = 0; i < 10 && tx_cnt == 0; i++) tick();
      check({tag, "_txen_count"}, tx_cnt, 1);
      check({tag, "_ack_byte"}, tx_last, exp_ack);
      tick_n(2);
      bus.TX_DONE = 1'b1;
      tick();
      bus.TX_DONE = 1'b0;
      tick_n(3);
      check({tag, "_txen_single"}, tx_cnt, 1);
   endtask

   task automatic play_window(input string tag, input int d, input int ncyc,
                              input logic [11:0] prev, input bit prev_known, input bit chk_data,
                              output logic [11:0] exp_now);
      int          bad;
      string       first;
      logic        exp_clk;
      logic [11:0] exp_dat;
      bit          dat_ok;
      bad   = 0;
      first = "none";
      for (int n = 0; n < ncyc; n++) begin
         exp_clk = ((n % (d + 1)) >= ((d + 1) / 2));
         exp_dat = dac_model(d, n, prev);
         dat_ok  = !chk_data || (!prev_known && n < d + 1) || (bus.DAC_DATA === exp_dat);
         if (bus.DAC_CLK !== exp_clk || bus.PLAY_ACTIVE !== 1'b1 || !dat_ok) begin
            if (bad == 0)
               first = $sformatf("n=%0d clk=%b/%b act=%b data=%0h/%0h", n, bus.DAC_CLK,
                                 exp_clk, bus.PLAY_ACTIVE, bus.DAC_DATA, exp_dat);
            bad++;
         end
         tick();
      end
      exp_now = dac_model(d, ncyc, prev);
      check({tag, "_bad_cycles (first ", first, ")"}, bad, 0);
   endtask

   initial begin
      logic [11:0] e_now;
      logic [11:0] e_prev;
      logic [11:0] prev;
      logic [3:0]  nib;
      int          d;
      int          chg;
      int          bad;
      logic        last_clk;

      rst_n        = 1'b0;
      bus.RX_DONE  = 1'b0;
      bus.RX_DATA  = 8'h00;
      bus.TX_VALID = 1'b0;
      bus.TX_DONE  = 1'b0;
      tick_n(3);
      check("rst_txen", bus.TXEN, 0);
      check("rst_tx_data", bus.TX_DATA, 0);
      check("rst_dac_clk", bus.DAC_CLK, 0);
      check("rst_dac_data", bus.DAC_DATA, 0);
      check("rst_play_active", bus.PLAY_ACTIVE, 0);
      check("rst_load_done", bus.LOAD_DONE, 0);
      rst_n = 1'b1;
      tick();

      // T2: ramp load, ACK held off by TX_VALID for 20 cycles
      for (int i = 0; i < N; i++) ram_model[i] = 16'(i);
      bus.TX_VALID = 1'b1;
      do_load(1'b0, 1'b1, "t2");
      ack_phase(20, 8'hA5, "t2");

      // T3: default divider 3 over a full period plus wrap
      send_byte(8'h05);
      play_window("t3_div3", 3, 1003 * 4, 12'h000, 1'b1, 1'b1, e_now);

      // T4: DIV 7 then PLAY restarts at word 0 with 8-cycle period
      send_byte(8'h74);
      e_prev = dac_model(3, 1003 * 4 + 1, 12'h000);
      send_byte(8'h05);
      play_window("t4_div7", 7, 40 * 8 + 3, e_prev, 1'b1, 1'b1, e_now);

      // DIV 0 stored as 1, applied at next wrap: period 2
      send_byte(8'h04);
      tick_n(12);
      prev     = bus.DAC_DATA;
      last_clk = bus.DAC_CLK;
      chg      = 0;
      bad      = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.DAC_CLK === last_clk) bad++;
         last_clk = bus.DAC_CLK;
         if (bus.DAC_DATA !== prev) begin
            chg++;
            if (bus.DAC_DATA !== ram_model[(int'(prev) + 1) % N][11:0]) bad++;
            prev = bus.DAC_DATA;
         end
      end
      check("t4_div1_changes", chg, 10);
      check("t4_div1_bad", bad, 0);

      // Random divider on the ramp
      nib = 4'($urandom_range(0, 15));
      d   = (nib == 4'd0) ? 1 : int'(nib);
      send_byte({nib, 4'h4});
      send_byte(8'h05);
      play_window("rand_div", d, 12 * (d + 1) + $urandom_range(0, d), 12'h000, 1'b0, 1'b1, e_now);

      // T5: LOAD during playback stops it on the next cycle, output frozen
      for (int i = 0; i < N; i++) ram_model[i] = 16'($urandom);
      send_byte(8'h03);
      check("t5_load_stops_play", bus.PLAY_ACTIVE, 0);
      check("t5_load_dac_clk", bus.DAC_CLK, 0);
      check("t5_load_dac_frozen", bus.DAC_DATA, e_now);
      bus.TX_VALID = 1'b1;
      do_load(1'b0, 1'b0, "t5");
      ack_phase($urandom_range(8, 30), 8'hA5, "t5");

      nib = 4'($urandom_range(1, 15));
      d   = int'(nib);
      send_byte({nib, 4'h4});
      send_byte(8'h05);
      play_window("t5_rand_data", d, 30 * (d + 1) + $urandom_range(0, d), e_now, 1'b1, 1'b1, e_now);

      // STOP mid-play
      send_byte(8'h06);
      check("stop_play_active", bus.PLAY_ACTIVE, 0);
      check("stop_dac_clk", bus.DAC_CLK, 0);
      check("stop_dac_held", bus.DAC_DATA, e_now);
      tick_n($urandom_range(10, 30));
      check("stop_dac_still_held", bus.DAC_DATA, e_now);
      check("stop_dac_clk_low", bus.DAC_CLK, 0);

      // T1: reset mid-play with divider 7, divider back to 3 afterwards
      send_byte(8'h74);
      send_byte(8'h05);
      tick_n($urandom_range(5, 20));
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_txen", bus.TXEN, 0);
      check("t1_tx_data", bus.TX_DATA, 0);
      check("t1_dac_clk", bus.DAC_CLK, 0);
      check("t1_dac_data", bus.DAC_DATA, 0);
      check("t1_play_active", bus.PLAY_ACTIVE, 0);
      check("t1_load_done", bus.LOAD_DONE, 0);
      tick_n(2);
      rst_n = 1'b1;
      tick();
      send_byte(8'h05);
      play_window("t1_div3_after_reset", 3, 40, 12'h000, 1'b1, 1'b0, e_now);
      send_byte(8'h06);

`ifdef LOAD_CHECKSUM_EN
      // T6: corrupted checksum byte
      for (int i = 0; i < N; i++) ram_model[i] = 16'($urandom);
      bus.TX_VALID = 1'b1;
      do_load(1'b1, 1'b1, "t6");
      ack_phase(10, 8'h5A, "t6");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
